// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command/register controller.
package spi_pkg;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_WDATA   = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    // No reset: a mid-frame controller reset must not fabricate a fresh CS edge.
    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns the spi_slave byte stream into register reads/writes on a small bank.
// Frame: command byte {rw, addr}, then auto-incrementing write data bytes.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [7:0]  ID_VALUE = 8'hA5,
    parameter int          ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic                  spi_cs,
    input  logic                  data_ready,
    input  logic [7:0]            received_data,
    output logic                  read_ack,
    output logic [7:0]            data_to_send,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic [7:0]            frame_count,
    output logic                  err
);

    localparam int               PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(NUM_REGS);
    localparam logic [7:0]       REGS_B  = 8'(NUM_REGS);

    state_e                   state, state_next;
    logic                     cs_s, cs_prev, cs_fall, cs_rise;
    logic                     consume;
    logic [CMD_ADDR_MSB:0]    cmd_addr;
    logic                     cmd_rw, cmd_bad;
    logic [ADDR_W-1:0]        cmd_idx, ptr_idx;
    logic [PTR_W-1:0]         ptr;
    logic                     ptr_valid;
    logic [NUM_REGS-1:0][7:0] bank;
    logic [7:0]               tx_hold;

    sync_2ff u_cs_sync (
        .clk (system_clk),
        .d   (spi_cs),
        .q   (cs_s)
    );

    always_ff @(posedge system_clk) begin
        cs_prev <= cs_s;
    end

    assign cs_fall   = cs_prev & ~cs_s;
    assign cs_rise   = ~cs_prev & cs_s;
    assign consume   = data_ready & ~read_ack;
    assign cmd_addr  = received_data[CMD_ADDR_MSB:0];
    assign cmd_rw    = received_data[CMD_RW_BIT];
    assign cmd_bad   = {1'b0, cmd_addr} >= REGS_B;
    assign cmd_idx   = cmd_addr[ADDR_W-1:0];
    assign ptr_idx   = ptr[ADDR_W-1:0];
    assign ptr_valid = ptr < PTR_END;

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte consumed in the closing cycle is still processed; the frame end wins the state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cs_fall) state_next = ST_CMD;
            ST_CMD:  if (consume) state_next = (cmd_bad || cmd_rw) ? ST_DISCARD : ST_WDATA;
            default: ;
        endcase
        if (cs_rise && state != ST_IDLE) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge system_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
            tx_hold      <= ID_VALUE;
            data_to_send <= ID_VALUE;
            read_ack     <= 1'b0;
            wr_strobe    <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_count  <= '0;
            err          <= 1'b0;
            ptr          <= '0;
        end else begin
            read_ack  <= consume;
            wr_strobe <= 1'b0;
            if (state == ST_IDLE) begin
                data_to_send <= tx_hold;
            end
            if (consume) begin
                case (state)
                    ST_CMD: begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else if (cmd_rw) begin
                            tx_hold <= (cmd_idx == '0) ? ID_VALUE : bank[cmd_idx];
                        end else begin
                            ptr <= {1'b0, cmd_idx};
                        end
                    end
                    ST_WDATA: begin
                        if (ptr_valid) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr_idx;
                            wr_data   <= received_data;
                            ptr       <= ptr + 1'b1;
                            // Register 1 bit 7 is a write-only error clear.
                            if (ptr_idx == ADDR_W'(1)) begin
                                bank[1] <= {1'b0, received_data[6:0]};
                                if (received_data[7]) begin
                                    err <= 1'b0;
                                end
                            end else if (ptr_idx != '0) begin
                                bank[ptr_idx] <= received_data;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (cs_rise && state != ST_IDLE) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    always_comb begin
        regs_out      = bank;
        regs_out[7:0] = ID_VALUE;
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random frames vs a frame-level model.
module tb_spi_reg_ctrl;

    localparam int         N  = 8;
    localparam int         AW = 3;
    localparam logic [7:0] ID = 8'hA5;

    logic           system_clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           spi_cs = 1'b1;
    logic           data_ready = 1'b0;
    logic [7:0]     received_data = 8'h00;
    logic           read_ack;
    logic [7:0]     data_to_send;
    logic [N*8-1:0] regs_out;
    logic           wr_strobe;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     wr_data;
    logic [7:0]     frame_count;
    logic           err;

    spi_reg_ctrl #(.NUM_REGS(N), .ID_VALUE(ID)) dut (
        .system_clk    (system_clk),
        .rst_n         (rst_n),
        .spi_cs        (spi_cs),
        .data_ready    (data_ready),
        .received_data (received_data),
        .read_ack      (read_ack),
        .data_to_send  (data_to_send),
        .regs_out      (regs_out),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_count   (frame_count),
        .err           (err)
    );

    always #5 system_clk = ~system_clk;

    // Frame-level reference model: register array, byte index within frame, CS seen 2-3 edges late.
    logic [7:0]    m_regs [N];
    logic          m_ack, m_strobe, m_err;
    logic [AW-1:0] m_waddr;
    logic [7:0]    m_wdata, m_fc, m_tx, m_cmd;
    bit            m_in_frame;
    int            m_idx, m_idle;
    logic          pad_hist [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bit            check_en = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    int            strobes_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*8-1:0] exp_regs();
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) begin
            v[i*8 +: 8] = (i == 0) ? ID : m_regs[i];
        end
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic dr, input logic [7:0] b, input logic pad);
        bit rise, fall, consumed;
        int a, tgt;
        for (int i = 3; i > 0; i--) begin
            pad_hist[i] = pad_hist[i-1];
        end
        pad_hist[0] = pad;
        rise = pad_hist[2] && !pad_hist[3];
        fall = !pad_hist[2] && pad_hist[3];
        if (!r) begin
            for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
            m_ack = 0; m_strobe = 0; m_err = 0; m_waddr = '0; m_wdata = 0;
            m_fc = 0; m_tx = ID; m_in_frame = 0; m_idx = 0; m_idle = 1; m_cmd = 0;
            return;
        end
        consumed = dr && !m_ack;
        m_ack    = consumed;
        m_strobe = 0;
        if (consumed && m_in_frame) begin
            if (m_idx == 0) begin
                m_cmd = b;
                a = int'(b[6:0]);
                if (a >= N) m_err = 1;
                else if (b[7]) m_tx = (a == 0) ? ID : m_regs[a];
            end else if (!m_cmd[7] && int'(m_cmd[6:0]) < N) begin
                tgt = int'(m_cmd[6:0]) + m_idx - 1;
                if (tgt < N) begin
                    m_strobe = 1;
                    m_waddr  = tgt[AW-1:0];
                    m_wdata  = b;
                    if (tgt == 1) begin
                        m_regs[1] = {1'b0, b[6:0]};
                        if (b[7]) m_err = 0;
                    end else if (tgt != 0) begin
                        m_regs[tgt] = b;
                    end
                end else begin
                    m_err = 1;
                end
            end
            m_idx++;
        end
        if (m_in_frame && rise) begin
            m_fc++;
            m_in_frame = 0;
            m_idle = 0;
        end else if (!m_in_frame) begin
            if (fall) begin
                m_in_frame = 1;
                m_idx = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic cycle();
        logic r = rst_n;
        logic dr = data_ready;
        logic [7:0] b = received_data;
        logic p = spi_cs;
        @(posedge system_clk);
        #1;
        model_edge(r, dr, b, p);
        check_en = 1'b1;
    endtask

    always @(negedge system_clk) begin
        if (check_en) begin
            check("read_ack", read_ack, m_ack);
            check("wr_strobe", wr_strobe, m_strobe);
            check("wr_addr", wr_addr, m_waddr);
            check("wr_data", wr_data, m_wdata);
            check("frame_count", frame_count, m_fc);
            check("err", err, m_err);
            check("regs_out", regs_out, exp_regs());
            if (!m_in_frame && m_idle >= 1) check("data_to_send", data_to_send, m_tx);
            if (wr_strobe) strobes_seen++;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
        received_data = b;
        data_ready = 1'b1;
        repeat (hold) cycle();
        data_ready = 1'b0;
        repeat (gap) cycle();
    endtask

    task automatic frame_begin();
        spi_cs = 1'b0;
        repeat (4) cycle();
    endtask

    task automatic frame_end();
        repeat (2) cycle();
        spi_cs = 1'b1;
        repeat (5) cycle();
    endtask

    task automatic run_frame(input logic [7:0] bytes [$]);
        frame_begin();
        foreach (bytes[i]) applyStimulus(bytes[i], 1 + (i % 2), 1);
        frame_end();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        repeat (5) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        checkOutput("lit_reset_dts", data_to_send, 8'hA5);

        frame_begin();
        checkOutput("lit_empty_dts", data_to_send, 8'hA5);
        frame_end();
        checkOutput("lit_empty_fc", frame_count, 8'd1);
        checkOutput("lit_empty_err", err, 1'b0);

        strobes_seen = 0;
        run_frame('{8'h02, 8'h11, 8'h22});
        checkOutput("lit_wr_strobes", strobes_seen, 2);
        checkOutput("lit_reg2", regs_out[23:16], 8'h11);
        checkOutput("lit_reg3", regs_out[31:24], 8'h22);

        run_frame('{8'h83});
        checkOutput("lit_read_dts", data_to_send, 8'h22);
        frame_begin();
        checkOutput("lit_next_miso", data_to_send, 8'h22);
        frame_end();

        run_frame('{8'h06, 8'hAA, 8'hBB, 8'hCC});
        checkOutput("lit_reg6", regs_out[55:48], 8'hAA);
        checkOutput("lit_reg7", regs_out[63:56], 8'hBB);
        checkOutput("lit_ovf_err", err, 1'b1);

        run_frame('{8'h01, 8'h80});
        checkOutput("lit_clr_err", err, 1'b0);
        strobes_seen = 0;
        run_frame('{8'h90});
        checkOutput("lit_bad_err", err, 1'b1);
        checkOutput("lit_bad_strobes", strobes_seen, 0);
        run_frame('{8'h01, 8'h80});
        checkOutput("lit_clr_err2", err, 1'b0);
        checkOutput("lit_reg1", regs_out[15:8], 8'h00);

        frame_begin();
        applyStimulus(8'h02, 1, 1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        strobes_seen = 0;
        applyStimulus(8'h55, 1, 1);
        frame_end();
        checkOutput("lit_abort_fc", frame_count, 8'd0);
        checkOutput("lit_abort_reg2", regs_out[23:16], 8'h00);
        checkOutput("lit_abort_strobes", strobes_seen, 0);

        for (int f = 0; f < 40; f++) begin
            int nb = $urandom_range(0, 5);
            frame_begin();
            for (int k = 0; k < nb; k++) begin
                logic [7:0] b = 8'($urandom);
                if (k == 0) b = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11))};
                applyStimulus(b, $urandom_range(1, 2), $urandom_range(1, 3));
                if (k == 0 && $urandom_range(0, 9) == 0) begin
                    rst_n = 1'b0;
                    cycle();
                    rst_n = 1'b1;
                end
            end
            frame_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller that sits directly behind spi_slave and turns its raw byte stream into register reads and writes.
- Consumes received_data/data_ready, returns read_ack, and drives data_to_send.
- Owns a small register bank exported to the rest of the design as a flat bus, plus a write-strobe side channel.
- Frame protocol: byte 0 = command {rw, addr[6:0]}; following bytes = write data with auto-increment. Read data is returned in the first byte of the next frame.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; legal range 2..128.
- ID_VALUE, 8'hA5, read-only contents of register 0.
- ADDR_W, $clog2(NUM_REGS), internal address width; derived, do not override.

Ports:
- system_clk  input  1  system clock; same clock as spi_slave.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- spi_cs  input  1  chip select from the pad, active low; asynchronous, synchronised internally.
- data_ready  input  1  byte-available flag from spi_slave.
- received_data  input  8  received byte from spi_slave.
- read_ack  output  1  one-cycle acknowledge to spi_slave.
- data_to_send  output  8  byte loaded by spi_slave while CS is high.
- regs_out  output  NUM_REGS*8  register bank; reg i occupies bits [8i+7:8i]; reg 0 reads as ID_VALUE.
- wr_strobe  output  1  one-cycle pulse per accepted register write.
- wr_addr  output  ADDR_W  address of the current write.
- wr_data  output  8  data of the current write.
- frame_count  output  8  number of completed frames; wraps at 255->0.
- err  output  1  sticky error flag; cleared only by reset or by writing register 1 bit 7.

Behaviour:
- Reset (rst_n=0 at a system_clk edge):
  - regs 1..N-1 = 0; tx_hold = ID_VALUE; data_to_send = ID_VALUE.
  - read_ack = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, frame_count = 0, err = 0.
  - State = IDLE.
- CS synchronisation: two-flop synchroniser gives cs_s. Frame start = cs_s 1->0; frame end = cs_s 0->1.
- Byte handshake:
  - On any cycle with data_ready=1 and read_ack=0, the byte is consumed and read_ack=1 for exactly the next cycle.
  - Next byte accepted no earlier than 2 cycles after the previous one.
  - data_ready seen while read_ack=1 is ignored; it is the same byte.
- States:
  - IDLE: waiting for frame start; data_to_send = tx_hold. Frame start -> CMD.
  - CMD: first consumed byte is the command.
    - addr >= NUM_REGS: err <= 1 -> DISCARD.
    - rw=1 (read): tx_hold <= reg[addr], using ID_VALUE for addr 0 -> DISCARD.
    - rw=0 (write): ptr <= addr -> WDATA.
  - WDATA: each consumed byte is a write to reg[ptr].
    - Writes to ptr=0 are ignored, but wr_strobe still pulses.
    - wr_strobe=1 in the cycle after consumption, with wr_addr=ptr and wr_data=byte; reg updates on the same edge.
    - Then ptr <= ptr+1.
    - ptr reaches NUM_REGS: further bytes in the frame are discarded, err <= 1, state stays WDATA.
  - DISCARD: bytes are consumed and acked, no side effects.
- Frame end from any non-IDLE state: frame_count <= frame_count+1 -> IDLE.
  - tx_hold is unchanged unless a read command occurred.
  - A frame ending in CMD with no byte is still counted.
- Precedence:
  - Frame end and data_ready in the same cycle: the byte is consumed first, then the frame closes.
  - rst_n=0 mid-frame aborts the frame without incrementing frame_count.
- Register 1 bit 7 write: clears err. Bit 7 always reads back 0; bits 6:0 are stored normally.
- Latency:
  - data_ready -> read_ack: 1 cycle.
  - data_ready -> wr_strobe/reg update: 1 cycle.
  - Pad CS edge -> state change: 2-3 cycles.

Decomposition:
- Shared package spi_pkg holds:
  - localparams CMD_RW_BIT=7 and CMD_ADDR_MSB=6.
  - State encoding constants ST_IDLE=0, ST_CMD=1, ST_WDATA=2, ST_DISCARD=3.
- Natural sub-module: sync_2ff (one-bit two-flop synchroniser) for spi_cs; also reusable elsewhere.
- Register bank and FSM stay inline in spi_reg_ctrl.

Test Plan:
- Reset then CS low, no bytes, CS high: frame_count=1, err=0; data_to_send=8'hA5 throughout.
- Frame {8'h02, 8'h11, 8'h22}: wr_strobe pulses twice, at (2,11) and (3,22); regs_out reg2=11, reg3=22; read_ack one cycle per byte.
- Frame {8'h83}, then a second frame: data_to_send=8'h22 after the first frame ends; the second frame's first MISO byte is 22.
- NUM_REGS=8, frame {8'h06, 8'hAA, 8'hBB, 8'hCC}: reg6=AA, reg7=BB, CC dropped, err=1.
- Frame {8'h90}: err=1, no wr_strobe. Then frame {8'h01, 8'h80}: err=0, reg1=00.
- rst_n low for 1 cycle after the write command byte of {8'h02, 8'h55}: reg2 stays 0, frame_count=0, state IDLE, no wr_strobe.
